// File: rtl/morty_pipe_pkg.sv
// Shared types for the morty pipeline stage register.
// State encoding, ID/EX payload layout and pack/unpack helpers.
package morty_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int EXC_W_DFLT = 11;

  localparam int RD_W  = 5;
  localparam int PC_W  = 32;
  localparam int OP_W  = 32;
  localparam int CSR_W = 53;
  localparam int IMM_W = 32;

  localparam int IDEX_W = RD_W + 2 * PC_W + 3 * OP_W
                        + CSR_W + IMM_W;

  // rd sits in the least significant bits
  typedef struct packed {
    logic [IMM_W-1:0] drs1_imm;
    logic [CSR_W-1:0] csr;
    logic [OP_W-1:0]  r2;
    logic [OP_W-1:0]  port_b;
    logic [OP_W-1:0]  port_a;
    logic [PC_W-1:0]  pc4;
    logic [PC_W-1:0]  pc;
    logic [RD_W-1:0]  rd;
  } idex_t;

  function automatic logic [IDEX_W-1:0] idex_pack(
    input idex_t f
  );
    return f;
  endfunction

  function automatic idex_t idex_unpack(
    input logic [IDEX_W-1:0] b
  );
    return idex_t'(b);
  endfunction

endpackage

// File: rtl/morty_pipe_slot.sv
// One pipeline entry: payload, exception causes and valid bit.
// Clear wins over load; both are synchronous.
module morty_pipe_slot #(
  parameter int DATA_W = 250,
  parameter int EXC_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [EXC_W-1:0]  load_exc,
  output logic              vld,
  output logic              [DATA_W-1:0] data,
  output logic [EXC_W-1:0]  exc
);

  // entry register: zeroed on reset/clear, captured on load
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld  <= 1'b0;
      data <= '0;
      exc  <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= load_data;
      exc  <= load_exc;
    end
  end

endmodule

// File: rtl/morty_pipe_stage.sv
// Valid/ready pipeline stage with optional skid entry, stall, flush.
// Oldest entry always lives in main; skid only holds the second one.
module morty_pipe_stage
  import morty_pipe_pkg::*;
#(
  parameter int DATA_W   = IDEX_W,
  parameter int EXC_W    = EXC_W_DFLT,
  parameter bit SKID_EN  = 1'b1,
  parameter bit ZERO_INV = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [EXC_W-1:0]  exc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [EXC_W-1:0]  exc_o,
  output logic              exc_pend_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  state_e state;
  state_e state_n;

  logic              main_v;
  logic [DATA_W-1:0] main_data;
  logic [EXC_W-1:0]  main_exc;
  logic              skid_v;
  logic [DATA_W-1:0] skid_data;
  logic [EXC_W-1:0]  skid_exc;

  logic              main_ld;
  logic              main_sel;
  logic              main_clr;
  logic              skid_ld;
  logic              skid_clr;
  logic [DATA_W-1:0] main_ld_data;
  logic [EXC_W-1:0]  main_ld_exc;

  logic in_x;
  logic out_x;

  assign in_x  = valid_i & ready_o;
  assign out_x = valid_o & ready_i;

  assign main_ld_data = main_sel ? skid_data : data_i;
  assign main_ld_exc  = main_sel ? skid_exc  : exc_i;

  morty_pipe_slot #(
    .DATA_W (DATA_W),
    .EXC_W  (EXC_W)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .clr       (main_clr),
    .load      (main_ld),
    .load_data (main_ld_data),
    .load_exc  (main_ld_exc),
    .vld       (main_v),
    .data      (main_data),
    .exc       (main_exc)
  );

  if (SKID_EN) begin : g_skid
    morty_pipe_slot #(
      .DATA_W (DATA_W),
      .EXC_W  (EXC_W)
    ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clr       (skid_clr),
      .load      (skid_ld),
      .load_data (data_i),
      .load_exc  (exc_i),
      .vld       (skid_v),
      .data      (skid_data),
      .exc       (skid_exc)
    );
  end else begin : g_noskid
    assign skid_v    = 1'b0;
    assign skid_data = '0;
    assign skid_exc  = '0;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  // next state and slot steering; flush beats any handshake
  always_comb begin
    state_n  = state;
    main_ld  = 1'b0;
    main_sel = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    if (flush_i) begin
      state_n  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_x) begin
            state_n = ONE;
            main_ld = 1'b1;
          end
        end
        ONE: begin
          if (in_x && out_x) begin
            main_ld = 1'b1;
          end else if (in_x) begin
            state_n = SKID_EN ? TWO : ONE;
            skid_ld = 1'b1;
          end else if (out_x) begin
            state_n  = EMPTY;
            main_clr = 1'b1;
          end
        end
        TWO: begin
          if (out_x) begin
            state_n  = ONE;
            main_ld  = 1'b1;
            main_sel = 1'b1;
            skid_clr = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // handshake and visible payload; stall masks the output side
  always_comb begin
    valid_o = main_v & ~stall_i;
    if (SKID_EN)
      ready_o = (state != TWO) & ~stall_i & ~rst;
    else
      ready_o = (~valid_o | ready_i) & ~stall_i & ~rst;
    data_o = main_data;
    exc_o  = main_exc;
    if (ZERO_INV && !valid_o) begin
      data_o = '0;
      exc_o  = '0;
    end
  end

  assign exc_pend_o = valid_o & (|exc_o);
  assign occ_o = {1'b0, main_v} + {1'b0, skid_v};

  // saturating perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (!valid_o && ready_i && !stall_i
          && bubble_cnt_o != '1)
        bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      if (flush_i && occ_o != 2'd0
          && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule
